// File: rtl/mem_test_pkg.sv
// Shared definitions for the on-chip memory test: march states, pattern
// selector encodings and the default geometry used by array and initiator.
package mem_test_pkg;

    localparam int ADDR_BITS_DEF = 5;
    localparam int DATA_BITS_DEF = 8;
    localparam int TIMEOUT_DEF   = 15;
    localparam int WAIT_BITS     = 4;
    localparam int ERR_BITS      = 8;

    localparam logic [1:0] PAT_SEED    = 2'd0;
    localparam logic [1:0] PAT_CHECKER = 2'd1;
    localparam logic [1:0] PAT_ADDR    = 2'd2;
    localparam logic [1:0] PAT_PARITY  = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W0   = 3'd1,
        R0   = 3'd2,
        W1   = 3'd3,
        R1   = 3'd4,
        FIN  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// Combinational march data pattern: seed xor an address-derived mask,
// optionally inverted for the second march element.
module mem_pattern_gen
    import mem_test_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_BITS-1:0] seed_i,
    input  logic [1:0]           sel_i,
    input  logic                 invert_i,
    output logic [DATA_BITS-1:0] pat_o
);

    logic [DATA_BITS-1:0] mask_s;
    logic [DATA_BITS-1:0] base_s;

    // Select the address-derived mask and apply the optional inversion.
    always_comb begin
        mask_s = '0;
        case (sel_i)
            PAT_SEED:    mask_s = '0;
            PAT_CHECKER: mask_s = {DATA_BITS{addr_i[0]}};
            PAT_ADDR:    mask_s = DATA_BITS'(addr_i);
            PAT_PARITY:  mask_s = {DATA_BITS{addr_i[0] ^ addr_i[1]}};
            default:     mask_s = '0;
        endcase
        base_s = seed_i ^ mask_s;
        if (invert_i) begin
            pat_o = ~base_s;
        end else begin
            pat_o = base_s;
        end
    end

endmodule

// File: rtl/mem_march_initiator.sv
// March-test initiator: ascending write, ascending read/write-inverse,
// descending read of the inverse, with error count, first failing address
// and a per-request acknowledge timeout.
module mem_march_initiator
    import mem_test_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           pattern_sel,
    input  logic [DATA_BITS-1:0] seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_BITS-1:0]  err_count,
    output logic [ADDR_BITS-1:0] first_err_addr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata
);

    localparam logic [ADDR_BITS-1:0] ADDR_MAX  = {ADDR_BITS{1'b1}};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);
    localparam logic [WAIT_BITS-1:0] WAIT_ONE  = WAIT_BITS'(1);
    localparam logic [WAIT_BITS-1:0] WAIT_LAST = WAIT_BITS'(TIMEOUT - 1);
    localparam logic [ERR_BITS-1:0]  ERR_ONE   = ERR_BITS'(1);

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] seed_q, seed_d;
    logic [1:0]           sel_q, sel_d;
    logic [WAIT_BITS-1:0] wait_q, wait_d;
    logic [ERR_BITS-1:0]  err_q, err_d;
    logic [ADDR_BITS-1:0] first_q, first_d;
    logic                 timeout_q, timeout_d;
    logic                 pass_q, pass_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;

    logic                 fire_s;
    logic                 cmp_s;
    logic                 exp_inv_s;
    logic                 wr_inv_s;
    logic [DATA_BITS-1:0] exp_s;
    logic [DATA_BITS-1:0] wpat_s;

    assign fire_s    = req_q & mem_ack;
    assign exp_inv_s = (state_q == R1);
    assign wr_inv_s  = (state_d == W1);

    // Expected read data for the address currently being read.
    mem_pattern_gen #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_exp_pat (
        .addr_i   (addr_q),
        .seed_i   (seed_q),
        .sel_i    (sel_q),
        .invert_i (exp_inv_s),
        .pat_o    (exp_s)
    );

    // Write data for the next request, so mem_wdata can be registered.
    mem_pattern_gen #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) u_wr_pat (
        .addr_i   (addr_d),
        .seed_i   (seed_d),
        .sel_i    (sel_d),
        .invert_i (wr_inv_s),
        .pat_o    (wpat_s)
    );

    // March sequencing, compare bookkeeping, ack timeout and next outputs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        seed_d    = seed_q;
        sel_d     = sel_q;
        wait_d    = wait_q;
        err_d     = err_q;
        first_d   = first_q;
        timeout_d = timeout_q;
        pass_d    = pass_q;
        cmp_s     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d    = seed;
                    sel_d     = pattern_sel;
                    err_d     = '0;
                    first_d   = '0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    addr_d    = '0;
                    state_d   = W0;
                end else begin
                    state_d = IDLE;
                end
            end
            W0: begin
                if (fire_s && (addr_q == ADDR_MAX)) begin
                    addr_d  = '0;
                    state_d = R0;
                end else if (fire_s) begin
                    addr_d = addr_q + ADDR_ONE;
                end else begin
                    state_d = W0;
                end
            end
            R0: begin
                if (fire_s) begin
                    cmp_s   = 1'b1;
                    state_d = W1;
                end else begin
                    state_d = R0;
                end
            end
            W1: begin
                if (fire_s && (addr_q == ADDR_MAX)) begin
                    state_d = R1;
                end else if (fire_s) begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = R0;
                end else begin
                    state_d = W1;
                end
            end
            R1: begin
                if (fire_s && (addr_q == '0)) begin
                    cmp_s   = 1'b1;
                    state_d = FIN;
                end else if (fire_s) begin
                    cmp_s  = 1'b1;
                    addr_d = addr_q - ADDR_ONE;
                end else begin
                    state_d = R1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Each new request starts with a fresh wait count; a stalled one aborts the test.
        if (req_q && fire_s) begin
            wait_d = '0;
        end else if (req_q && (wait_q == WAIT_LAST)) begin
            wait_d    = '0;
            timeout_d = 1'b1;
            state_d   = FIN;
        end else if (req_q) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = '0;
        end

        if (cmp_s && (mem_rdata != exp_s)) begin
            if (err_q != {ERR_BITS{1'b1}}) begin
                err_d = err_q + ERR_ONE;
            end else begin
                err_d = err_q;
            end
            if (err_q == '0) begin
                first_d = addr_q;
            end else begin
                first_d = first_q;
            end
        end else begin
            err_d = err_d;
        end

        if (state_d == FIN) begin
            pass_d = (err_d == '0) && !timeout_d;
            addr_d = '0;
        end else begin
            pass_d = pass_d;
        end

        busy_d  = (state_d == W0) || (state_d == R0) || (state_d == W1) || (state_d == R1);
        req_d   = busy_d;
        we_d    = (state_d == W0) || (state_d == W1);
        done_d  = (state_d == FIN);
        if (we_d) begin
            wdata_d = wpat_s;
        end else begin
            wdata_d = '0;
        end
    end

    // State and registered outputs; reset drops mem_req immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            seed_q    <= '0;
            sel_q     <= 2'd0;
            wait_q    <= '0;
            err_q     <= '0;
            first_q   <= '0;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            first_q   <= first_d;
            timeout_q <= timeout_d;
            pass_q    <= pass_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            req_q     <= req_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;
    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;

endmodule

// File: tb/tb_mem_march_initiator.sv
// Bench for mem_march_initiator: a responder with a model RAM (optional
// faults and random ack delays) plus an expected-transaction queue built
// directly from the march algorithm.
module tb_mem_march_initiator;

    localparam int D = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [7:0] seed = 8'd0;
    logic       busy, done, pass, timeout, mem_req, mem_we, mem_ack;
    logic [7:0] err_count, mem_wdata, mem_rdata;
    logic [4:0] first_err_addr, mem_addr;

    mem_march_initiator dut (
        .clk(clk), .reset(reset), .start(start), .pattern_sel(pattern_sel), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed { logic we; logic [4:0] addr; logic [7:0] data; } txn_t;

    txn_t q[$];
    logic [7:0] ram [D];
    int total = 0, bad = 0;
    int m_err, m_first, acks, req_cycles, wait_cnt, cur_delay, max_delay, fault_mode;
    bit m_first_set, exp_done_next, never_ack, mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_pat(input int a, input logic [7:0] s, input int sel, input bit inv);
        int m;
        case (sel)
            0:       m = 0;
            1:       m = (a % 2 == 1) ? 255 : 0;
            2:       m = a;
            default: m = ((a % 2) != ((a / 2) % 2)) ? 255 : 0;
        endcase
        ref_pat = s ^ 8'(m);
        if (inv) ref_pat = ~ref_pat;
    endfunction

    // The whole march, as an ordered list of transfers.
    task automatic prep(input logic [7:0] s, input int sel, input int maxd, input int fm, input bit nev);
        q.delete();
        for (int a = 0; a < D; a++) q.push_back({1'b1, 5'(a), ref_pat(a, s, sel, 1'b0)});
        for (int a = 0; a < D; a++) begin
            q.push_back({1'b0, 5'(a), ref_pat(a, s, sel, 1'b0)});
            q.push_back({1'b1, 5'(a), ref_pat(a, s, sel, 1'b1)});
        end
        for (int a = D - 1; a >= 0; a--) q.push_back({1'b0, 5'(a), ref_pat(a, s, sel, 1'b1)});
        m_err = 0; m_first = 0; m_first_set = 1'b0; acks = 0; req_cycles = 0;
        exp_done_next = 1'b0; max_delay = maxd; fault_mode = fm; never_ack = nev;
        wait_cnt = 0; cur_delay = $urandom_range(0, maxd);
        seed = s; pattern_sel = 2'(sel);
    endtask

    // Responder and per-cycle compare against the expected transfer queue.
    initial begin
        txn_t h;
        logic [7:0] rd;
        mem_ack = 1'b0; mem_rdata = 8'd0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                mem_ack = 1'b0;
            end else begin
                if (!never_ack) chk("done_timing", done, exp_done_next);
                exp_done_next = 1'b0;
                if (busy) chk("err_running", err_count, m_err);
                mem_ack = 1'b0;
                if (mem_req && q.size() == 0) begin
                    chk("extra_req", mem_req, 1'b0);
                end else if (mem_req) begin
                    h = q[0];
                    chk("req_we", mem_we, h.we);
                    chk("req_addr", mem_addr, h.addr);
                    if (h.we) chk("req_wdata", mem_wdata, h.data);
                    req_cycles++;
                    if (!never_ack && wait_cnt >= cur_delay) begin
                        mem_ack = 1'b1;
                        acks++;
                        if (h.we) begin
                            ram[mem_addr] = (fault_mode == 1 && mem_addr == 5'd7) ? (mem_wdata | 8'h08) : mem_wdata;
                        end else begin
                            rd = ram[mem_addr];
                            if (fault_mode == 2) rd = rd ^ 8'h01;
                            mem_rdata = rd;
                            if (rd != h.data) begin
                                if (!m_first_set) m_first = h.addr;
                                m_first_set = 1'b1;
                                m_err = (m_err < 255) ? m_err + 1 : 255;
                            end
                        end
                        void'(q.pop_front());
                        wait_cnt = 0;
                        cur_delay = $urandom_range(0, max_delay);
                        if (q.size() == 0) exp_done_next = 1'b1;
                    end else begin
                        wait_cnt++;
                    end
                end else begin
                    // acks with no request outstanding must be ignored
                    mem_ack = 1'($urandom_range(0, 1));
                    mem_rdata = 8'($urandom);
                end
            end
        end
    end

    // Pulse start, optionally poke start mid-test and in the FIN cycle, wait for done.
    task automatic run(input bit extra_start, input bit fin_start);
        bit got = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed = 8'($urandom); pattern_sel = 2'($urandom);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = (extra_start && (c == 10 || c == 200)) ? 1'b1 : 1'b0;
            if (done) begin
                got = 1'b1;
                start = fin_start;
                break;
            end
        end
        if (!got) chk("done_seen", 1'b0, 1'b1);
    endtask

    task automatic check_final(input int exp_err, input int exp_first, input bit exp_to);
        chk("final_err", err_count, exp_err);
        chk("final_first", first_err_addr, exp_first);
        chk("final_timeout", timeout, exp_to);
        chk("final_pass", pass, (exp_err == 0 && !exp_to) ? 1 : 0);
        chk("final_busy", busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("pass_held", pass, (exp_err == 0 && !exp_to) ? 1 : 0);
        repeat (3) @(negedge clk);
        chk("idle_req", mem_req, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, busy, 0); chk({nm, "_done"}, done, 0); chk({nm, "_pass"}, pass, 0);
        chk({nm, "_to"}, timeout, 0); chk({nm, "_err"}, err_count, 0);
        chk({nm, "_first"}, first_err_addr, 0); chk({nm, "_req"}, mem_req, 0);
        chk({nm, "_we"}, mem_we, 0); chk({nm, "_addr"}, mem_addr, 0); chk({nm, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        bit got;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // ideal responder, plus a start in the FIN cycle that must be ignored
        prep(8'hA5, 0, 0, 0, 1'b0);
        run(1'b0, 1'b1);
        chk("t1_transfers", acks, 128);
        check_final(0, 0, 1'b0);

        // bit3 stuck-at-1 at address 7: only the R0 read differs
        prep(8'h00, 2, 1, 1, 1'b0);
        run(1'b0, 1'b0);
        chk("t2_err_lit", err_count, 1);
        chk("t2_first_lit", first_err_addr, 7);
        check_final(m_err, m_first, 1'b0);

        // no acknowledge at all
        prep(8'h3C, 1, 0, 0, 1'b1);
        run(1'b0, 1'b0);
        chk("t3_req_cycles", req_cycles, 15);
        chk("t3_req_low", mem_req, 1'b0);
        check_final(0, 0, 1'b1);
        never_ack = 1'b0;

        // random delays and stray start pulses while busy
        prep(8'($urandom), $urandom_range(0, 3), 3, 0, 1'b0);
        run(1'b1, 1'b0);
        chk("t4_transfers", acks, 128);
        check_final(0, 0, 1'b0);

        // every read corrupted
        prep(8'($urandom), 3, 2, 2, 1'b0);
        run(1'b0, 1'b0);
        chk("t5_err_lit", err_count, 64);
        check_final(m_err, m_first, 1'b0);

        // asynchronous reset during R0
        prep(8'h5A, 1, 2, 0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (q.size() <= 80) begin got = 1'b1; break; end
        end
        chk("t6_reached_r0", got, 1'b1);
        chk("t6_req_before", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        mon_en = 1'b0;
        mem_ack = 1'b0;
        #1;
        chk_zero("t6_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t6_no_done", done, 1'b0);
            chk("t6_no_busy", busy, 1'b0);
        end
        mon_en = 1'b1;

        // clean run after reset
        prep(8'($urandom), 1, 1, 0, 1'b0);
        run(1'b0, 1'b0);
        chk("t7_transfers", acks, 128);
        check_final(0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
